ascon_perm_arbiter: RTL

Shared-permutation scheduler for the Ascon cores. It owns one `ascon_permutation` instance and time-multiplexes it between `NREQ` requesters, such as the AEAD encrypt and decrypt engines and a future hash engine, using round-robin arbitration. It also validates the round count and guards each job with a watchdog, so one faulty job cannot stall the other requesters.

---
 rtl/ascon_pkg.sv | 31 +++
 rtl/ascon_permutation.sv | 89 ++++++++
 rtl/ascon_rr_pick.sv | 25 ++
 rtl/ascon_perm_arbiter.sv | 124 ++++++++++++
 4 files changed

// File: rtl/ascon_pkg.sv
// Shared Ascon types and constants for the permutation scheduler.
// State words are big-endian: x0 = state[319:256] ... x4 = state[63:0].
package ascon_pkg;

    localparam int ASCON_STATE_W  = 320;
    localparam int ASCON_ROUNDS_W = 5;

    localparam logic [ASCON_ROUNDS_W-1:0] ROUNDS_6  = 5'd6;
    localparam logic [ASCON_ROUNDS_W-1:0] ROUNDS_8  = 5'd8;
    localparam logic [ASCON_ROUNDS_W-1:0] ROUNDS_12 = 5'd12;

    localparam logic [63:0] IV_128 = 64'h80400c0600000000;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_RUN,
        ARB_DRAIN,
        ARB_RESP
    } arb_state_e;

    typedef enum logic [1:0] {
        P_IDLE,
        P_BUSY,
        P_DONE
    } perm_state_e;

    function automatic logic rounds_ok(input logic [ASCON_ROUNDS_W-1:0] r);
        return (r == ROUNDS_6) || (r == ROUNDS_8) || (r == ROUNDS_12);
    endfunction

endpackage

// File: rtl/ascon_permutation.sv
// Ascon permutation, up to six rounds per cycle; start is held for the job.
// done stays high until start drops; dropping start mid-run aborts.
module ascon_permutation
    import ascon_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic [ASCON_ROUNDS_W-1:0] rounds,
    input  logic [ASCON_STATE_W-1:0]  state_in,
    output logic                      done,
    output logic [ASCON_STATE_W-1:0]  state_out
);

    function automatic logic [63:0] ror(input logic [63:0] x, input int n);
        return (x >> n) | (x << (64 - n));
    endfunction

    function automatic logic [319:0] ascon_round(input logic [319:0] s,
                                                 input logic [3:0] i);
        logic [63:0] x0, x1, x2, x3, x4, t0, t1, t2, t3, t4;
        {x0, x1, x2, x3, x4} = s;
        x2 = x2 ^ {56'd0, ~i, i};
        x0 = x0 ^ x4; x4 = x4 ^ x3; x2 = x2 ^ x1;
        t0 = ~x0 & x1; t1 = ~x1 & x2; t2 = ~x2 & x3;
        t3 = ~x3 & x4; t4 = ~x4 & x0;
        x0 = x0 ^ t1; x1 = x1 ^ t2; x2 = x2 ^ t3;
        x3 = x3 ^ t4; x4 = x4 ^ t0;
        x1 = x1 ^ x0; x0 = x0 ^ x4; x3 = x3 ^ x2; x2 = ~x2;
        x0 = x0 ^ ror(x0, 19) ^ ror(x0, 28);
        x1 = x1 ^ ror(x1, 61) ^ ror(x1, 39);
        x2 = x2 ^ ror(x2, 1) ^ ror(x2, 6);
        x3 = x3 ^ ror(x3, 10) ^ ror(x3, 17);
        x4 = x4 ^ ror(x4, 7) ^ ror(x4, 41);
        return {x0, x1, x2, x3, x4};
    endfunction

    perm_state_e ph, pnxt;
    logic [ASCON_STATE_W-1:0] s, src, stepped;
    logic [3:0] ridx, rem, r4, i0, left, n;

    assign r4 = (rounds > ROUNDS_12) ? 4'd12 : rounds[3:0];

    always_comb begin
        pnxt = ph;
        src  = s;
        i0   = ridx;
        left = rem;
        unique case (ph)
            P_IDLE: begin
                src  = state_in;
                i0   = 4'd12 - r4;
                left = r4;
                if (start) pnxt = (r4 > 4'd6) ? P_BUSY : P_DONE;
            end
            P_BUSY: begin
                if (!start) pnxt = P_IDLE;
                else if (rem <= 4'd6) pnxt = P_DONE;
            end
            P_DONE: if (!start) pnxt = P_IDLE;
            default: pnxt = P_IDLE;
        endcase
        n = (left > 4'd6) ? 4'd6 : left;
        stepped = src;
        for (int k = 0; k < 6; k++) begin
            if (4'(k) < n) stepped = ascon_round(stepped, i0 + 4'(k));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ph   <= P_IDLE;
            s    <= '0;
            ridx <= '0;
            rem  <= '0;
        end else begin
            ph <= pnxt;
            if (start && (ph == P_IDLE || ph == P_BUSY)) begin
                s    <= stepped;
                ridx <= i0 + n;
                rem  <= left - n;
            end
        end
    end

    assign done      = (ph == P_DONE);
    assign state_out = s;

endmodule

// File: rtl/ascon_rr_pick.sv
// Round-robin picker: first set bit of req at or after ptr, wrapping.
module ascon_rr_pick #(
    parameter int N  = 2,
    parameter int IW = 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt_onehot,
    output logic [IW-1:0] gnt_idx
);

    always_comb begin
        gnt_onehot = '0;
        gnt_idx    = '0;
        // Walk from farthest to nearest so the nearest requester wins.
        for (int k = N - 1; k >= 0; k--) begin
            if (req[(int'(ptr) + k) % N]) begin
                gnt_onehot = '0;
                gnt_onehot[(int'(ptr) + k) % N] = 1'b1;
                gnt_idx = IW'((int'(ptr) + k) % N);
            end
        end
    end

endmodule

// File: rtl/ascon_perm_arbiter.sv
// Round-robin scheduler sharing one Ascon permutation between requesters,
// with round-count validation and a per-job watchdog.
module ascon_perm_arbiter
    import ascon_pkg::*;
#(
    parameter int NREQ    = 2,
    parameter int TIMEOUT = 64,
    localparam int IDW    = (NREQ > 2) ? $clog2(NREQ) : 1
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [NREQ-1:0]                 req_valid,
    output logic [NREQ-1:0]                 req_ready,
    input  logic [ASCON_ROUNDS_W*NREQ-1:0]  req_rounds,
    input  logic [ASCON_STATE_W*NREQ-1:0]   req_state,
    output logic [NREQ-1:0]                 resp_valid,
    input  logic [NREQ-1:0]                 resp_ready,
    output logic [ASCON_STATE_W-1:0]        resp_state,
    output logic                            resp_err,
    output logic                            busy,
    output logic [IDW-1:0]                  owner
);

    localparam int WDW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 1);

    arb_state_e st, nxt;
    logic [NREQ-1:0] gnt;
    logic [IDW-1:0] gnt_idx, job_id, rr_ptr;
    logic [ASCON_ROUNDS_W-1:0] win_rounds, job_rounds;
    logic [ASCON_STATE_W-1:0] win_state, job_state, res_state, perm_state_out;
    logic [WDW-1:0] wd_cnt;
    logic err, perm_start, perm_done, xfer, win_ok;

    ascon_rr_pick #(.N(NREQ), .IW(IDW)) u_pick (
        .req        (req_valid),
        .ptr        (rr_ptr),
        .gnt_onehot (gnt),
        .gnt_idx    (gnt_idx)
    );

    ascon_permutation u_perm (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (perm_start),
        .rounds    (job_rounds),
        .state_in  (job_state),
        .done      (perm_done),
        .state_out (perm_state_out)
    );

    assign win_rounds = req_rounds[int'(gnt_idx)*ASCON_ROUNDS_W +: ASCON_ROUNDS_W];
    assign win_state  = req_state[int'(gnt_idx)*ASCON_STATE_W +: ASCON_STATE_W];
    assign win_ok     = rounds_ok(win_rounds);
    assign xfer       = (st == ARB_IDLE) && (|gnt);

    always_comb begin
        nxt        = st;
        req_ready  = '0;
        resp_valid = '0;
        unique case (st)
            ARB_IDLE: begin
                req_ready = gnt;
                if (xfer) nxt = win_ok ? ARB_RUN : ARB_RESP;
            end
            ARB_RUN: if (perm_done || wd_cnt == WD_LAST) nxt = ARB_DRAIN;
            ARB_DRAIN: if (!perm_done) nxt = ARB_RESP;
            ARB_RESP: begin
                resp_valid[job_id] = 1'b1;
                if (resp_ready[job_id]) nxt = ARB_IDLE;
            end
            default: nxt = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st         <= ARB_IDLE;
            job_state  <= '0;
            job_rounds <= '0;
            job_id     <= '0;
            rr_ptr     <= '0;
            wd_cnt     <= '0;
            res_state  <= '0;
            err        <= 1'b0;
            perm_start <= 1'b0;
        end else begin
            st <= nxt;
            unique case (st)
                ARB_IDLE: if (xfer) begin
                    job_state  <= win_state;
                    job_rounds <= win_rounds;
                    job_id     <= gnt_idx;
                    wd_cnt     <= '0;
                    perm_start <= win_ok;
                    err        <= !win_ok;
                    if (!win_ok) res_state <= win_state;
                end
                ARB_RUN: begin
                    wd_cnt <= wd_cnt + 1'b1;
                    if (perm_done) begin
                        res_state  <= perm_state_out;
                        err        <= 1'b0;
                        perm_start <= 1'b0;
                    end else if (wd_cnt == WD_LAST) begin
                        res_state  <= job_state;
                        err        <= 1'b1;
                        perm_start <= 1'b0;
                    end
                end
                ARB_RESP: if (resp_ready[job_id]) begin
                    rr_ptr <= (job_id == IDW'(NREQ - 1)) ? '0 : job_id + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign resp_state = res_state;
    assign resp_err   = err;
    assign busy       = (st != ARB_IDLE);
    assign owner      = (st == ARB_IDLE) ? '0 : job_id;

endmodule
